radar_sweep_ctrl: RTL and testbench

Sweep sequencer for the radar head, directly upstream of the servo PWM generator. It steps the servo pulse-width command across the sweep range one position at a time. At each position it waits a mechanical settle time, then issues a request/acknowledge handshake to the ranging stage. At each end of travel it reverses direction, producing a continuous back-and-forth scan with one range sample per angle.

---
 rtl/radar_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_radar_sweep_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/radar_sweep_ctrl.sv
// rtl/radar_sweep_ctrl.sv - servo sweep sequencer: settle, range handshake, step, reverse at travel ends
// One position per SETTLE -> MEASURE -> STEP cycle; all outputs registered.
module radar_sweep_ctrl #(
   parameter int unsigned PW_MIN       = 1600,
   parameter int unsigned PW_MAX       = 66000,
   parameter int unsigned PW_STEP      = 400,
   parameter int unsigned SETTLE_CYC   = 1350000,
   parameter int unsigned MEAS_TIMEOUT = 1620000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        meas_ack,
   output logic [19:0] pw,
   output logic [7:0]  step_idx,
   output logic        dir,
   output logic        meas_req,
   output logic        meas_timeout,
   output logic        sweep_done,
   output logic        busy
);

   localparam int unsigned N_STEPS     = (PW_MAX - PW_MIN) / PW_STEP;
   localparam logic [7:0]  IDX_LAST    = 8'(N_STEPS);
   localparam logic [19:0] PW_HOME     = 20'(PW_MAX);
   localparam logic [19:0] PW_INC      = 20'(PW_STEP);
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
   localparam logic [31:0] TMO_LAST    = 32'(MEAS_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_STEP} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [19:0] pw_q, pw_d;
   logic [7:0]  idx_q, idx_d;
   logic        dir_q, dir_d;
   logic        req_q, req_d;
   logic        tmo_q, tmo_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pw_q    <= PW_HOME;
         idx_q   <= '0;
         dir_q   <= 1'b0;
         req_q   <= 1'b0;
         tmo_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pw_q    <= pw_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         req_q   <= req_d;
         tmo_q   <= tmo_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // One counter serves both the settle wait and the ack timeout; it is cleared on every entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pw_d    = pw_q;
      idx_d   = idx_q;
      dir_d   = dir_q;
      req_d   = req_q;
      tmo_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_MEASURE;
               req_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_MEASURE: begin
            if (meas_ack) begin
               req_d   = 1'b0;
               state_d = S_STEP;
            end else if (cnt_q == TMO_LAST) begin
               req_d   = 1'b0;
               tmo_d   = 1'b1;
               state_d = S_STEP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_STEP: begin
            // Guards keep pw inside [PW_MIN, PW_MAX] even if dir and idx ever disagree.
            if (!dir_q) begin
               if (idx_q < IDX_LAST) begin
                  pw_d  = pw_q - PW_INC;
                  idx_d = idx_q + 8'd1;
                  if (idx_q + 8'd1 == IDX_LAST) begin
                     dir_d  = 1'b1;
                     done_d = 1'b1;
                  end
               end
            end else begin
               if (idx_q != 8'd0) begin
                  pw_d  = pw_q + PW_INC;
                  idx_d = idx_q - 8'd1;
                  if (idx_q == 8'd1) begin
                     dir_d  = 1'b0;
                     done_d = 1'b1;
                  end
               end
            end
            cnt_d   = '0;
            state_d = enable ? S_SETTLE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign pw           = pw_q;
   assign step_idx     = idx_q;
   assign dir          = dir_q;
   assign meas_req     = req_q;
   assign meas_timeout = tmo_q;
   assign sweep_done   = done_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// tb/tb_radar_sweep_ctrl.sv - vector table plus directed sequences for radar_sweep_ctrl
module tb_radar_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        meas_ack = 1'b0;
   logic [19:0] pw;
   logic [7:0]  step_idx;
   logic        dir, meas_req, meas_timeout, sweep_done, busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   radar_sweep_ctrl #(
      .PW_MIN(1600), .PW_MAX(66000), .PW_STEP(400), .SETTLE_CYC(4), .MEAS_TIMEOUT(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .meas_ack(meas_ack),
      .pw(pw), .step_idx(step_idx), .dir(dir), .meas_req(meas_req),
      .meas_timeout(meas_timeout), .sweep_done(sweep_done), .busy(busy)
   );

   typedef struct {
      logic        rst_n, en, ack;
      logic [19:0] pw;
      logic [7:0]  idx;
      logic        dir, req, tmo, done, busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic e, input logic a, input int p,
                               input int i, input logic d, input logic q, input logic t,
                               input logic dn, input logic b);
      vec_t v;
      v.rst_n = r; v.en = e; v.ack = a; v.pw = 20'(p); v.idx = 8'(i);
      v.dir = d; v.req = q; v.tmo = t; v.done = dn; v.busy = b;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int  ndone;
   bit  range_ok, found, stray_ok;
   int  req_cycles;

   initial begin
      // reset, idle, enable, ack three cycles after the request, stop in STEP, stray ack in IDLE
      vecs.push_back(mk(0,0,0, 66000,0,0,0,0,0,0));
      for (int i = 0; i < 20; i++) vecs.push_back(mk(1,0,0, 66000,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0, 66000,0,0,0,0,0,1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,0, 66000,0,0,0,0,0,1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,0, 66000,0,0,1,0,0,1));
      vecs.push_back(mk(1,1,1, 66000,0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0, 65600,1,0,0,0,0,0));
      vecs.push_back(mk(1,0,1, 65600,1,0,0,0,0,0));
      vecs.push_back(mk(1,0,0, 65600,1,0,0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n; enable = vecs[i].en; meas_ack = vecs[i].ack;
         tick();
         chk($sformatf("v%0d.pw", i),   32'(pw),           32'(vecs[i].pw));
         chk($sformatf("v%0d.idx", i),  32'(step_idx),     32'(vecs[i].idx));
         chk($sformatf("v%0d.dir", i),  32'(dir),          32'(vecs[i].dir));
         chk($sformatf("v%0d.req", i),  32'(meas_req),     32'(vecs[i].req));
         chk($sformatf("v%0d.tmo", i),  32'(meas_timeout), 32'(vecs[i].tmo));
         chk($sformatf("v%0d.done", i), 32'(sweep_done),   32'(vecs[i].done));
         chk($sformatf("v%0d.busy", i), 32'(busy),         32'(vecs[i].busy));
      end

      // full sweep out and back with immediate ack
      rst_n = 1'b0; enable = 1'b0; meas_ack = 1'b0;
      tick();
      rst_n = 1'b1; enable = 1'b1; meas_ack = 1'b1;
      ndone = 0; range_ok = 1'b1;
      for (int c = 0; c < 5000 && ndone < 2; c++) begin
         tick();
         if (pw < 20'd1600 || pw > 20'd66000) range_ok = 1'b0;
         if (sweep_done) begin
            ndone++;
            if (ndone == 1) begin
               chk("sweep.far_idx", 32'(step_idx), 32'd161);
               chk("sweep.far_pw",  32'(pw),       32'd1600);
               chk("sweep.far_dir", 32'(dir),      32'd1);
            end else begin
               chk("sweep.home_idx", 32'(step_idx), 32'd0);
               chk("sweep.home_pw",  32'(pw),       32'd66000);
               chk("sweep.home_dir", 32'(dir),      32'd0);
            end
         end
      end
      chk("sweep.done_count", 32'(ndone), 32'd2);
      chk("sweep.pw_range", 32'(range_ok), 32'd1);

      // never ack: request held five cycles, one timeout pulse, step advances
      rst_n = 1'b0; enable = 1'b0; meas_ack = 1'b0;
      tick();
      rst_n = 1'b1; enable = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         if (meas_req) found = 1'b1;
      end
      chk("tmo.req_seen", 32'(found), 32'd1);
      req_cycles = found ? 1 : 0;
      for (int c = 0; c < 20 && meas_req; c++) begin
         tick();
         if (meas_req) req_cycles++;
      end
      chk("tmo.req_len", 32'(req_cycles), 32'd5);
      chk("tmo.pulse", 32'(meas_timeout), 32'd1);
      tick();
      chk("tmo.pulse_width", 32'(meas_timeout), 32'd0);
      chk("tmo.idx", 32'(step_idx), 32'd1);
      chk("tmo.pw", 32'(pw), 32'd65600);

      // ack on the fifth cycle of the request wins over the timeout
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         if (meas_req) found = 1'b1;
      end
      chk("ack5.req_seen", 32'(found), 32'd1);
      for (int c = 0; c < 4; c++) tick();
      chk("ack5.req_held", 32'(meas_req), 32'd1);
      meas_ack = 1'b1;
      tick();
      meas_ack = 1'b0;
      chk("ack5.req_drop", 32'(meas_req), 32'd0);
      chk("ack5.no_tmo", 32'(meas_timeout), 32'd0);
      tick();
      chk("ack5.idx", 32'(step_idx), 32'd2);

      // enable dropped mid-SETTLE at index 10
      rst_n = 1'b0; enable = 1'b0;
      tick();
      rst_n = 1'b1; enable = 1'b1; meas_ack = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         tick();
         if (step_idx == 8'd10) found = 1'b1;
      end
      chk("drop.reach10", 32'(found), 32'd1);
      tick();
      enable = 1'b0;
      for (int c = 0; c < 50 && busy; c++) tick();
      chk("drop.idle", 32'(busy), 32'd0);
      chk("drop.idx", 32'(step_idx), 32'd11);
      chk("drop.pw", 32'(pw), 32'd61600);
      for (int c = 0; c < 5; c++) tick();
      chk("drop.hold_idx", 32'(step_idx), 32'd11);
      enable = 1'b1;
      for (int c = 0; c < 50 && step_idx == 8'd11; c++) tick();
      chk("resume.idx", 32'(step_idx), 32'd12);
      chk("resume.pw", 32'(pw), 32'd61200);

      // reset during MEASURE at index 50
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         tick();
         if (step_idx == 8'd50) found = 1'b1;
      end
      chk("rst.reach50", 32'(found), 32'd1);
      meas_ack = 1'b0;
      for (int c = 0; c < 20 && !meas_req; c++) tick();
      tick();
      tick();
      chk("rst.req_open", 32'(meas_req), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rst.req", 32'(meas_req), 32'd0);
      chk("rst.pw", 32'(pw), 32'd66000);
      chk("rst.idx", 32'(step_idx), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      rst_n = 1'b1; enable = 1'b0; meas_ack = 1'b1;
      stray_ok = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (meas_req || busy || step_idx != 8'd0 || pw != 20'd66000 || meas_timeout || sweep_done)
            stray_ok = 1'b0;
      end
      chk("rst.stray_ack", 32'(stray_ok), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
